// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined Urdhva-Tiryagbhyam multiplier with a single global stall.
// Define VEDIC_SIGNED_EN to add the in_signed port and two's-complement operand support.
module vedic_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef VEDIC_SIGNED_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;

  // Handshake: a transfer happens only when valid && ready on the same edge.
  // in_ready = adv is combinational; once out_valid rises it holds, with out_p
  // stable, until out_ready completes the transfer. All stages move together on adv.
  logic adv;
  logic v1, v2, v3;

  logic [WIDTH-1:0] a1, b1;
  logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic [W2-1:0]    p3;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [W2:0]      ll_x, cross_x, hh_x;
  logic [W2-1:0]    sum, p_next;

  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign out_p     = p3;
  assign busy      = v1 || v2 || v3;

`ifdef VEDIC_SIGNED_EN
  logic sign_a, sign_b, neg_in, neg1, neg2;

  // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude.
  assign sign_a = in_signed && in_a[WIDTH-1];
  assign sign_b = in_signed && in_b[WIDTH-1];
  assign mag_a  = sign_a ? (~in_a + WIDTH'(1)) : in_a;
  assign mag_b  = sign_b ? (~in_b + WIDTH'(1)) : in_b;
  assign neg_in = sign_a ^ sign_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg1 <= 1'b0;
      neg2 <= 1'b0;
    end else if (adv) begin
      if (in_valid) neg1 <= neg_in;
      neg2 <= neg1;
    end
  end

  assign p_next = neg2 ? (~sum + W2'(1)) : sum;
`else
  assign mag_a  = in_a;
  assign mag_b  = in_b;
  assign p_next = sum;
`endif

  // The cross sum needs WIDTH+1 bits; the full sum fits exactly in 2*WIDTH.
  assign ll_x    = (W2+1)'(pp_ll);
  assign cross_x = (W2+1)'(pp_lh) + (W2+1)'(pp_hl);
  assign hh_x    = (W2+1)'(pp_hh);
  assign sum     = W2'(ll_x + (cross_x << H) + (hh_x << WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1 <= mag_a;
        b1 <= mag_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      pp_ll <= '0;
      pp_lh <= '0;
      pp_hl <= '0;
      pp_hh <= '0;
    end else if (adv) begin
      v2    <= v1;
      pp_ll <= WIDTH'(a1[H-1:0])     * WIDTH'(b1[H-1:0]);
      pp_lh <= WIDTH'(a1[H-1:0])     * WIDTH'(b1[WIDTH-1:H]);
      pp_hl <= WIDTH'(a1[WIDTH-1:H]) * WIDTH'(b1[H-1:0]);
      pp_hh <= WIDTH'(a1[WIDTH-1:H]) * WIDTH'(b1[WIDTH-1:H]);
    end
  end

  // Bubbles load zero so out_p reads 0 whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0;
      p3 <= '0;
    end else if (adv) begin
      v3 <= v2;
      p3 <= v2 ? p_next : '0;
    end
  end

endmodule
